// File: rtl/cpu_run_pkg.sv
// Shared types and defaults for the CPU run controller and its counters.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cpu_run_pkg;

  // Run controller phases: reset sequencing, core running, run finished
  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RUN      = 2'd1,
    DONE     = 2'd2
  } run_state_t;

  // Default build-time settings
  localparam int unsigned DEF_RESET_CYCLES = 2;
  localparam int unsigned DEF_CYCLE_BUDGET = 1000;
  localparam int unsigned DEF_CNT_W        = 16;
  localparam int unsigned DEF_LOOP_CYCLES  = 4;

  // The reset-hold counter only ever needs to reach 254 (RESET_CYCLES <= 255)
  localparam int unsigned HOLD_W = 8;

  // Bits needed for a counter that must be able to hold max_val
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that saturates at all-ones instead of wrapping.
// Latency: count updates on the edge after inc/clr; clr takes priority over inc.
// Backpressure: none; an increment at all-ones is absorbed and the count holds.
module sat_counter
  import cpu_run_pkg::*;
#(
  parameter int unsigned W = HOLD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear beats increment, increment stops at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: sequences core reset/enable, counts RUN cycles, ends run on halt or budget.
// Latency: all outputs registered; status changes on the edge that decides it.
// Backpressure: none; halt_req is a level sampled only in RUN. Optional PC-loop halt: CPU_RUN_CTRL_PC_LOOP_EN.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int unsigned CYCLE_BUDGET = DEF_CYCLE_BUDGET,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned LOOP_CYCLES  = DEF_LOOP_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt_req,
  input  logic [63:0]      pc,
  output logic             core_reset,
  output logic             core_en,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  // Last hold count before entering RUN, and last count before the budget trips
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BUDGET_LAST = CNT_W'(CYCLE_BUDGET - 1);
  localparam bit                BUDGET_EN   = (CYCLE_BUDGET != 0);

  run_state_t        state_q;
  run_state_t        state_d;
  logic              core_reset_q;
  logic              core_reset_d;
  logic              core_en_q;
  logic              core_en_d;
  logic              running_q;
  logic              running_d;
  logic              done_q;
  logic              done_d;
  logic              timeout_q;
  logic              timeout_d;

  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_last;
  logic              hold_inc;
  logic              cyc_inc;
  logic              cyc_clr;
  logic              budget_hit;
  logic              loop_halt;
  logic              halt_hit;

  // ---------------------------------------------------------------------------
  // Reset hold sequencing: count low-reset edges until RESET_CYCLES have passed
  // ---------------------------------------------------------------------------
  assign hold_last = (hold_cnt == HOLD_LAST);
  assign hold_inc  = (state_q == RST_HOLD) && !hold_last;

  sat_counter #(
    .W (HOLD_W)
  ) u_hold_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (hold_inc),
    .cnt   (hold_cnt)
  );

  // ---------------------------------------------------------------------------
  // RUN cycle counter; saturates when the budget is unlimited
  // ---------------------------------------------------------------------------
  assign cyc_inc = (state_q == RUN);
  assign cyc_clr = (state_q == RST_HOLD);

  sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cyc_clr),
    .inc   (cyc_inc),
    .cnt   (cycle_count)
  );

  assign budget_hit = BUDGET_EN && (cycle_count == BUDGET_LAST);

`ifdef CPU_RUN_CTRL_PC_LOOP_EN
  // ---------------------------------------------------------------------------
  // PC-loop detector: a core spinning on one PC is treated as a halt request
  // ---------------------------------------------------------------------------
  localparam int unsigned        LOOP_W    = cnt_width(LOOP_CYCLES);
  localparam logic [LOOP_W-1:0]  LOOP_LAST = LOOP_W'(LOOP_CYCLES - 1);

  logic [63:0]       pc_q;
  logic [63:0]       pc_d;
  logic              pc_vld_q;
  logic              pc_vld_d;
  logic              loop_same;
  logic              loop_inc;
  logic              loop_clr;
  logic [LOOP_W-1:0] loop_cnt;

  // Capture the PC every RUN cycle; the first RUN cycle has nothing to compare against
  always_comb begin
    pc_d     = pc_q;
    pc_vld_d = 1'b0;
    if (state_q == RUN) begin
      pc_d     = pc;
      pc_vld_d = 1'b1;
    end
  end

  // Previous-PC register
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      pc_vld_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      pc_vld_q <= pc_vld_d;
    end
  end

  assign loop_same = (state_q == RUN) && pc_vld_q && (pc == pc_q);
  assign loop_inc  = loop_same;
  assign loop_clr  = !loop_same;

  sat_counter #(
    .W (LOOP_W)
  ) u_loop_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (loop_clr),
    .inc   (loop_inc),
    .cnt   (loop_cnt)
  );

  // Halt on the edge where the unchanged-PC count reaches LOOP_CYCLES
  assign loop_halt = loop_same && (loop_cnt == LOOP_LAST);
`else
  // Without the loop detector the PC has no influence on the run
  logic unused_pc;
  assign unused_pc = ^{pc, LOOP_CYCLES[0]};
  assign loop_halt = 1'b0;
`endif

  assign halt_hit = halt_req || loop_halt;

  // ---------------------------------------------------------------------------
  // Phase sequencing and registered status; halt wins over a budget hit
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    unique case (state_q)
      RST_HOLD: begin
        if (hold_last) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (halt_hit) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (budget_hit) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = RST_HOLD;
      end
    endcase
    core_reset_d = (state_d == RST_HOLD);
    core_en_d    = (state_d == RUN);
    running_d    = (state_d == RUN);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RST_HOLD;
      core_reset_q <= 1'b1;
      core_en_q    <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_reset_q <= core_reset_d;
      core_en_q    <= core_en_d;
      running_q    <= running_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign core_reset = core_reset_q;
  assign core_en    = core_en_q;
  assign running    = running_q;
  assign done       = done_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: three instances (default, short budget, unlimited budget).
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: not applicable.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        halt_req;
  logic [63:0] pc;

  logic        cr0, en0, rn0, dn0, to0;
  logic [15:0] cc0;
  logic        cr1, en1, rn1, dn1, to1;
  logic [7:0]  cc1;
  logic        cr2, en2, rn2, dn2, to2;
  logic [3:0]  cc2;

  // Default build: RESET_CYCLES 2, budget 1000, 16-bit count
  cpu_run_ctrl dut (
    .clk(clk), .reset(reset), .halt_req(halt_req), .pc(pc),
    .core_reset(cr0), .core_en(en0), .running(rn0), .done(dn0),
    .timeout(to0), .cycle_count(cc0)
  );

  // Short budget: RESET_CYCLES 3, budget 5
  cpu_run_ctrl #(.RESET_CYCLES(3), .CYCLE_BUDGET(5), .CNT_W(8)) dut_b5 (
    .clk(clk), .reset(reset), .halt_req(halt_req), .pc(pc),
    .core_reset(cr1), .core_en(en1), .running(rn1), .done(dn1),
    .timeout(to1), .cycle_count(cc1)
  );

  // Unlimited budget with a narrow counter to exercise saturation
  cpu_run_ctrl #(.RESET_CYCLES(1), .CYCLE_BUDGET(0), .CNT_W(4)) dut_b0 (
    .clk(clk), .reset(reset), .halt_req(halt_req), .pc(pc),
    .core_reset(cr2), .core_en(en2), .running(rn2), .done(dn2),
    .timeout(to2), .cycle_count(cc2)
  );

  int n_chk = 0;
  int n_err = 0;
  bit model_on = 1'b1;
  bit pc_auto  = 1'b1;

  // Reference model: edges since reset release, RUN cycles done, and how the run ended
  int mr [3] = '{2, 3, 1};
  int mb [3] = '{1000, 5, 0};
  int mm [3] = '{65535, 255, 15};
  int low_edges [3];
  int runs [3];
  bit end_h [3];
  bit end_t [3];

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_n(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit h);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        low_edges[i] = 0;
        runs[i]      = 0;
        end_h[i]     = 1'b0;
        end_t[i]     = 1'b0;
      end else if (low_edges[i] < mr[i]) begin
        low_edges[i]++;
      end else if (!end_h[i] && !end_t[i]) begin
        runs[i]++;
        if (h) end_h[i] = 1'b1;
        else if (mb[i] != 0 && runs[i] == mb[i]) end_t[i] = 1'b1;
      end
    end
  endtask

  task automatic model_check();
    logic a_cr, a_en, a_rn, a_dn, a_to;
    int   a_cc;
    bit   e_run;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin a_cr = cr0; a_en = en0; a_rn = rn0; a_dn = dn0; a_to = to0; a_cc = 32'(cc0); end
        1: begin a_cr = cr1; a_en = en1; a_rn = rn1; a_dn = dn1; a_to = to1; a_cc = 32'(cc1); end
        default: begin a_cr = cr2; a_en = en2; a_rn = rn2; a_dn = dn2; a_to = to2; a_cc = 32'(cc2); end
      endcase
      e_run = (low_edges[i] >= mr[i]) && !end_h[i] && !end_t[i];
      chk_b($sformatf("m%0d.core_reset", i), a_cr, low_edges[i] < mr[i]);
      chk_b($sformatf("m%0d.core_en", i), a_en, e_run);
      chk_b($sformatf("m%0d.running", i), a_rn, e_run);
      chk_b($sformatf("m%0d.done", i), a_dn, end_h[i]);
      chk_b($sformatf("m%0d.timeout", i), a_to, end_t[i]);
      chk_n($sformatf("m%0d.cycle_count", i), a_cc, (runs[i] > mm[i]) ? mm[i] : runs[i]);
    end
  endtask

  // One clock: inputs already set, model follows the edge, outputs checked 1ns later
  task automatic step();
    bit r, h;
    r = reset;
    h = halt_req;
    @(posedge clk);
    model_edge(r, h);
    #1;
    if (model_on) model_check();
    if (pc_auto) pc = pc + 64'd4;
  endtask

  typedef struct {
    bit rst;
    bit halt;
    bit e_cr;
    bit e_en;
    bit e_run;
    bit e_done;
    bit e_to;
    int e_cnt;
  } vec_t;

  vec_t tbl [34];

  initial begin
    bit seen;

    reset    = 1'b1;
    halt_req = 1'b0;
    pc       = 64'd0;

    // Reset, hold, 10 RUN cycles with halt on the 10th, then 20 stable DONE cycles
    tbl[0] = '{1, 0, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 1, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 1, 1, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 1, 0, 1, 1, 0, 0, 0};
    for (int k = 1; k <= 9; k++) tbl[3 + k] = '{0, 0, 0, 1, 1, 0, 0, k};
    tbl[13] = '{0, 1, 0, 0, 0, 1, 0, 10};
    for (int k = 14; k < 34; k++) tbl[k] = '{0, bit'(k % 2), 0, 0, 0, 1, 0, 10};

    for (int i = 0; i < 34; i++) begin
      reset    = tbl[i].rst;
      halt_req = tbl[i].halt;
      step();
      chk_b($sformatf("vec%0d.core_reset", i), cr0, tbl[i].e_cr);
      chk_b($sformatf("vec%0d.core_en", i), en0, tbl[i].e_en);
      chk_b($sformatf("vec%0d.running", i), rn0, tbl[i].e_run);
      chk_b($sformatf("vec%0d.done", i), dn0, tbl[i].e_done);
      chk_b($sformatf("vec%0d.timeout", i), to0, tbl[i].e_to);
      chk_n($sformatf("vec%0d.cycle_count", i), 32'(cc0), tbl[i].e_cnt);
    end

    // Budget exhaustion on the default instance after exactly 1000 RUN cycles
    halt_req = 1'b0;
    reset = 1'b1; step();
    reset = 1'b0; step(); step();
    for (int i = 1; i <= 999; i++) step();
    chk_b("budget.running_at_999", rn0, 1'b1);
    chk_b("budget.timeout_at_999", to0, 1'b0);
    chk_n("budget.count_at_999", 32'(cc0), 999);
    step();
    chk_b("budget.timeout", to0, 1'b1);
    chk_b("budget.done", dn0, 1'b0);
    chk_b("budget.core_en", en0, 1'b0);
    chk_n("budget.count", 32'(cc0), 1000);
    step(); step();
    chk_n("budget.count_frozen", 32'(cc0), 1000);
    chk_b("b5.timeout", to1, 1'b1);
    chk_n("b5.count", 32'(cc1), 5);
    chk_n("b0.saturated", 32'(cc2), 15);
    chk_b("b0.still_running", rn2, 1'b1);

    // Halt on the same edge the 5-cycle budget would trip: halt wins
    reset = 1'b1; step();
    reset = 1'b0; step(); step(); step();
    for (int i = 1; i <= 4; i++) step();
    halt_req = 1'b1; step();
    halt_req = 1'b0;
    chk_b("b5_tie.done", dn1, 1'b1);
    chk_b("b5_tie.timeout", to1, 1'b0);
    chk_n("b5_tie.count", 32'(cc1), 5);

    // Reset at RUN cycle 7, then a full restart
    reset = 1'b1; step();
    reset = 1'b0; step(); step();
    for (int i = 1; i <= 6; i++) step();
    reset = 1'b1; step();
    chk_b("rerun.core_reset", cr0, 1'b1);
    chk_b("rerun.core_en", en0, 1'b0);
    chk_n("rerun.count_cleared", 32'(cc0), 0);
    reset = 1'b0; step();
    chk_b("rerun.hold", cr0, 1'b1);
    step();
    chk_b("rerun.running", rn0, 1'b1);
    chk_n("rerun.count_start", 32'(cc0), 0);
    step();
    chk_n("rerun.count_one", 32'(cc0), 1);

    // Randomised run/halt/reset traffic against the model
    for (int i = 0; i < 2000; i++) begin
      reset    = ($urandom_range(0, 149) == 0);
      halt_req = ($urandom_range(0, 39) == 0);
      step();
    end

    // PC parked on one address after 0x0, 0x4, 0x8
    halt_req = 1'b0;
    reset = 1'b1; step();
    reset = 1'b0; step(); step();
    pc_auto = 1'b0;
`ifdef CPU_RUN_CTRL_PC_LOOP_EN
    model_on = 1'b0;
`endif
    pc = 64'h0; step();
    pc = 64'h4; step();
    pc = 64'h8; step();
`ifdef CPU_RUN_CTRL_PC_LOOP_EN
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (dn0 === 1'b1) seen = 1'b1;
    end
    chk_b("loop.done", seen, 1'b1);
    chk_b("loop.timeout", to0, 1'b0);
    chk_n("loop.count", 32'(cc0), 7);
`else
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (dn0 === 1'b1) seen = 1'b1;
    end
    chk_b("noloop.done_seen", seen, 1'b0);
    chk_b("noloop.running", rn0, 1'b1);
    chk_n("noloop.count", 32'(cc0), 23);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run controller placed between the bench/top-level reset and the pipelined CPU core.
- Converts the raw reset into a sequenced core reset and a core enable.
- Counts executed cycles and ends the run on a core halt request or when the cycle budget is exhausted.
- Reports done/timeout status, so a bench can wait on a status flag instead of a fixed cycle count.

Parameters:
- RESET_CYCLES, 2, clock edges core_reset stays high after reset falls; legal range 1..255.
- CYCLE_BUDGET, 1000, maximum RUN cycles before timeout; 0 = unlimited.
- CNT_W, 16, width of cycle_count; must satisfy 2^CNT_W > CYCLE_BUDGET.
- LOOP_CYCLES, 4, consecutive unchanged-PC cycles that count as a halt; used only with the optional feature.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- halt_req  in  1  core requests end of run; sampled only in RUN.
- pc  in  64  core fetch PC; ignored unless the optional feature is compiled in.
- core_reset  out  1  reset to the CPU core, active-high.
- core_en  out  1  core clock enable; high only in RUN.
- running  out  1  state == RUN.
- done  out  1  run ended by a halt; sticky until reset.
- timeout  out  1  run ended by budget exhaustion; sticky until reset.
- cycle_count  out  CNT_W  number of RUN cycles executed.

Behaviour:
- FSM states: RST_HOLD, RUN, DONE. All outputs are registered.
- Reset (sampled high at an edge):
  - state = RST_HOLD, hold_cnt = 0.
  - core_reset = 1, core_en = 0, running = 0, done = 0, timeout = 0, cycle_count = 0.
  - Reset asserted in any state, including mid-RUN or DONE, returns the block to these values at the next edge.
- RST_HOLD:
  - Each edge with reset low: if hold_cnt == RESET_CYCLES-1, go to RUN; otherwise increment hold_cnt.
  - core_reset therefore stays high for exactly RESET_CYCLES edges after reset falls.
- Entering RUN: core_reset = 0, core_en = 1, running = 1, all in the same edge.
- RUN, each edge:
  - cycle_count increments by 1, including on the exiting edge.
  - halt_req = 1 → DONE with done = 1.
  - Else if CYCLE_BUDGET != 0 and cycle_count == CYCLE_BUDGET-1 → DONE with timeout = 1; cycle_count lands on CYCLE_BUDGET.
  - Simultaneous halt and budget hit: halt wins; done = 1, timeout = 0.
- DONE:
  - core_en = 0, core_reset = 0, running = 0.
  - cycle_count is frozen; halt_req is ignored.
  - done and timeout are mutually exclusive and hold until reset.
- Saturation: with CYCLE_BUDGET = 0, cycle_count saturates at all-ones and does not wrap; the run continues until halt_req.
- halt_req is ignored in RST_HOLD.

Optional Feature:
Macro CPU_RUN_CTRL_PC_LOOP_EN.
- Defined:
  - Register pc each RUN cycle and compare the current pc with the registered value.
  - loop_cnt increments while they are equal and clears when they differ.
  - When the count reaches LOOP_CYCLES, treat it as halt_req, with identical priority and effects.
  - loop_cnt clears on reset and on entry to RUN.
- Not defined: pc is unused, no PC register or loop counter exists, and behaviour depends only on halt_req.

Decomposition:
- Shared package cpu_run_pkg holds:
  - typedef enum logic [1:0] run_state_t {RST_HOLD, RUN, DONE};
  - default constants for RESET_CYCLES and CYCLE_BUDGET.
- One sub-module is natural: sat_counter, a parameterised-width counter with increment, clear and saturate.
  - Instantiated for cycle_count, hold_cnt, and loop_cnt when the feature is enabled.

Test Plan:
1. reset high for 2 edges, then low; RESET_CYCLES = 2 → core_reset is high for exactly 2 edges after the fall, then core_en = 1 and running = 1.
2. halt_req pulsed on the 10th RUN cycle → done = 1, timeout = 0, cycle_count = 10, core_en = 0; all remain stable for 20 more cycles.
3. CYCLE_BUDGET = 1000, halt_req held 0 → timeout = 1 with cycle_count = 1000 after exactly 1000 RUN cycles; done = 0.
4. CYCLE_BUDGET = 5, halt_req = 1 on the 5th RUN cycle → done = 1, timeout = 0, cycle_count = 5.
5. reset asserted at RUN cycle 7, released after 1 edge → all outputs return to reset values, then the full RST_HOLD→RUN sequence repeats with cycle_count restarting from 0.
6. With CPU_RUN_CTRL_PC_LOOP_EN, LOOP_CYCLES = 4: pc advances 0x0, 0x4, 0x8, then stays at 0x8 → done = 1 after 4 unchanged cycles. Without the macro, the same stimulus does not halt.
